// File: rtl/mem_lbarb_pkg.sv
// rtl/mem_lbarb_pkg.sv - shared states, default timing constants and counter sizing for the local memory arbiter
package mem_lbarb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU     = 3'd1,
    BUS     = 3'd2,
    REFRESH = 3'd3,
    RECOVER = 3'd4
  } arb_state_e;

  localparam int REF_INTERVAL_DEF   = 624;
  localparam int REF_CYCLES_DEF     = 8;
  localparam int RECOVER_CYCLES_DEF = 2;
  localparam int MAX_CYCLE_DEF      = 32;

  // Bits needed for a counter running 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_refresh_timer.sv
// rtl/mem_refresh_timer.sv - free-running refresh interval counter with a single pending request flag
module mem_refresh_timer
  import mem_lbarb_pkg::*;
#(
  parameter int REF_INTERVAL = REF_INTERVAL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ref_clr,
  output logic ref_pend
);

  localparam int CW = cnt_width(REF_INTERVAL);
  localparam logic [CW-1:0] CNT_LAST = CW'(REF_INTERVAL - 1);

  logic [CW-1:0] cnt;

  // Count every cycle; a wrap raises pending and outranks a same-cycle clear so no interval is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      ref_pend <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt      <= '0;
      ref_pend <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      if (ref_clr) begin
        ref_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_lbarb.sv
// rtl/mem_lbarb.sv - local memory arbiter between CPU, ND-bus and refresh; LBARB_TIMEOUT_EN adds a grant watchdog
module mem_lbarb
  import mem_lbarb_pkg::*;
#(
  parameter int REF_INTERVAL   = REF_INTERVAL_DEF,
  parameter int REF_CYCLES     = REF_CYCLES_DEF,
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF,
  parameter int MAX_CYCLE      = MAX_CYCLE_DEF
) (
  input  logic OSC,
  input  logic MR_n,
  input  logic CRQ_n,
  input  logic CWRITE_n,
  input  logic CDONE_n,
  input  logic BLRQ_n,
  input  logic BWRITE_n,
  input  logic BLOCKL_n,
  input  logic BDRY_n,
  input  logic MOR_n,
  output logic GNT_n,
  output logic CGNT_n,
  output logic BGNT_n,
  output logic REF_n,
  output logic MWRITE_n,
  output logic TOUT
);

  localparam int GMAX_A = (REF_CYCLES > RECOVER_CYCLES) ? REF_CYCLES : RECOVER_CYCLES;
  localparam int GMAX   = (MAX_CYCLE > GMAX_A) ? MAX_CYCLE : GMAX_A;
  localparam int GW     = cnt_width(GMAX);
  localparam logic [GW-1:0] REF_LAST = GW'(REF_CYCLES - 1);
  localparam logic [GW-1:0] REC_LAST = GW'(RECOVER_CYCLES - 1);

  arb_state_e    state, next_state;
  logic [GW-1:0] gcnt;
  logic          blrq_s1, blrq_s2, bwr_s1, bwr_s2;
  logic          fair, fair_set, fair_clr;
  logic          lock_cont;
  logic          mw_lat;
  logic          ref_pend, ref_clr;
  logic          bus_req, cpu_req;
  logic          cpu_hold, bus_hold;
  logic          wd_hit;

  assign bus_req  = !blrq_s2 && MOR_n;
  assign cpu_req  = !CRQ_n && MOR_n;
  assign ref_clr  = (state != REFRESH) && (next_state == REFRESH);
  // A grant is driven only while the master keeps the memory for another cycle, so release shows up one cycle after done.
  assign cpu_hold = (state == CPU) && (next_state == CPU);
  assign bus_hold = (state == BUS) && (next_state == BUS);

`ifdef LBARB_TIMEOUT_EN
  localparam logic [GW-1:0] MAX_LAST = GW'(MAX_CYCLE - 1);
  logic wd_fire;
  logic tout_q;

  assign wd_hit  = (gcnt == MAX_LAST);
  assign wd_fire = wd_hit && (((state == CPU) && CDONE_n) || ((state == BUS) && BDRY_n));
  assign TOUT    = tout_q;

  // Sticky watchdog flag, cleared only by master reset.
  always_ff @(posedge OSC or negedge MR_n) begin
    if (!MR_n) begin
      tout_q <= 1'b0;
    end else if (wd_fire) begin
      tout_q <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign TOUT   = 1'b0;
`endif

  mem_refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_refresh_timer (
    .clk     (OSC),
    .rst_n   (MR_n),
    .ref_clr (ref_clr),
    .ref_pend(ref_pend)
  );

  // Two-flop synchroniser for the asynchronous bus request and its write qualifier.
  always_ff @(posedge OSC or negedge MR_n) begin
    if (!MR_n) begin
      blrq_s1 <= 1'b1;
      blrq_s2 <= 1'b1;
      bwr_s1  <= 1'b1;
      bwr_s2  <= 1'b1;
    end else begin
      blrq_s1 <= BLRQ_n;
      blrq_s2 <= blrq_s1;
      bwr_s1  <= BWRITE_n;
      bwr_s2  <= bwr_s1;
    end
  end

  // Next-state decision: refresh first, then bus, then CPU, with the fairness bit letting the CPU win one tie.
  always_comb begin
    next_state = state;
    lock_cont  = 1'b0;
    fair_set   = 1'b0;
    fair_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (ref_pend) begin
          next_state = REFRESH;
        end else if (bus_req && cpu_req && fair) begin
          next_state = CPU;
          fair_clr   = 1'b1;
        end else if (bus_req) begin
          next_state = BUS;
        end else if (cpu_req) begin
          next_state = CPU;
        end
      end
      CPU: begin
        if (!CDONE_n || wd_hit) begin
          next_state = RECOVER;
        end
      end
      BUS: begin
        if (!BDRY_n) begin
          if (!BLOCKL_n && !blrq_s2 && !ref_pend) begin
            lock_cont = 1'b1;
          end else begin
            next_state = RECOVER;
            fair_set   = 1'b1;
          end
        end else if (wd_hit) begin
          next_state = RECOVER;
          fair_set   = 1'b1;
        end
      end
      REFRESH: begin
        if (gcnt == REF_LAST) begin
          next_state = RECOVER;
        end
      end
      RECOVER: begin
        if (gcnt == REC_LAST) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register plus the per-state cycle counter, restarted on every state change and every locked bus cycle.
  always_ff @(posedge OSC or negedge MR_n) begin
    if (!MR_n) begin
      state <= IDLE;
      gcnt  <= '0;
    end else begin
      state <= next_state;
      if ((next_state != state) || lock_cont || (state == IDLE)) begin
        gcnt <= '0;
      end else begin
        gcnt <= gcnt + 1'b1;
      end
    end
  end

  // Fairness bit and the write qualifier captured when a master is granted.
  always_ff @(posedge OSC or negedge MR_n) begin
    if (!MR_n) begin
      fair   <= 1'b0;
      mw_lat <= 1'b1;
    end else begin
      if (fair_set) begin
        fair <= 1'b1;
      end else if (fair_clr) begin
        fair <= 1'b0;
      end
      if ((state == IDLE) && (next_state == CPU)) begin
        mw_lat <= CWRITE_n;
      end else if ((state == IDLE) && (next_state == BUS)) begin
        mw_lat <= bwr_s2;
      end
    end
  end

  // Registered outputs towards the BD control stage.
  always_ff @(posedge OSC or negedge MR_n) begin
    if (!MR_n) begin
      GNT_n    <= 1'b1;
      CGNT_n   <= 1'b1;
      BGNT_n   <= 1'b1;
      REF_n    <= 1'b1;
      MWRITE_n <= 1'b1;
    end else begin
      GNT_n    <= !(cpu_hold || bus_hold);
      CGNT_n   <= !cpu_hold;
      BGNT_n   <= !bus_hold;
      REF_n    <= !(next_state == REFRESH);
      MWRITE_n <= (cpu_hold || bus_hold) ? mw_lat : 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_lbarb.sv
// tb/tb_mem_lbarb.sv - directed bench for mem_lbarb; covers LBARB_TIMEOUT_EN when that macro is defined
module tb_mem_lbarb;

  logic OSC, MR_n;
  logic CRQ_n, CWRITE_n, CDONE_n, BLRQ_n, BWRITE_n, BLOCKL_n, BDRY_n, MOR_n;
  logic GNT_n, CGNT_n, BGNT_n, REF_n, MWRITE_n, TOUT;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  mem_lbarb #(
    .REF_INTERVAL(16)
  ) u_dut (
    .OSC     (OSC),
    .MR_n    (MR_n),
    .CRQ_n   (CRQ_n),
    .CWRITE_n(CWRITE_n),
    .CDONE_n (CDONE_n),
    .BLRQ_n  (BLRQ_n),
    .BWRITE_n(BWRITE_n),
    .BLOCKL_n(BLOCKL_n),
    .BDRY_n  (BDRY_n),
    .MOR_n   (MOR_n),
    .GNT_n   (GNT_n),
    .CGNT_n  (CGNT_n),
    .BGNT_n  (BGNT_n),
    .REF_n   (REF_n),
    .MWRITE_n(MWRITE_n),
    .TOUT    (TOUT)
  );

  initial OSC = 1'b0;
  always #5 OSC = ~OSC;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge OSC);
    #1;
    cyc++;
  endtask

  task automatic go(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    CRQ_n = 1'b1; CWRITE_n = 1'b1; CDONE_n = 1'b1;
    BLRQ_n = 1'b1; BWRITE_n = 1'b1; BLOCKL_n = 1'b1;
    BDRY_n = 1'b1; MOR_n = 1'b1;
    MR_n = 1'b0;
    @(posedge OSC); #1;
    @(posedge OSC); #1;
    MR_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // reset values
    do_reset();
    check_vec("rst_gnt", GNT_n, 1);
    check_vec("rst_cgnt", CGNT_n, 1);
    check_vec("rst_bgnt", BGNT_n, 1);
    check_vec("rst_ref", REF_n, 1);
    check_vec("rst_mwrite", MWRITE_n, 1);
    check_vec("rst_tout", TOUT, 0);

    // CPU grant with a stray done while idle beforehand
    go(3); CDONE_n = 1'b0;
    go(4); CDONE_n = 1'b1;
    go(5); CRQ_n = 1'b0; CWRITE_n = 1'b0;
    go(6); check_vec("cpu_lat6", CGNT_n, 1);
    go(7);
    check_vec("cpu_cgnt7", CGNT_n, 0);
    check_vec("cpu_gnt7", GNT_n, 0);
    check_vec("cpu_mwr7", MWRITE_n, 0);
    check_vec("cpu_bgnt7", BGNT_n, 1);
    go(12); check_vec("cpu_cgnt12", CGNT_n, 0);
    CDONE_n = 1'b0; CRQ_n = 1'b1; CWRITE_n = 1'b1;
    go(13); CDONE_n = 1'b1;
    check_vec("cpu_rel13", CGNT_n, 1);
    check_vec("cpu_gnt13", GNT_n, 1);
    check_vec("cpu_mwr13", MWRITE_n, 1);
    go(14); check_vec("cpu_rec14", GNT_n, 1);
    go(15); check_vec("cpu_idle15", GNT_n, 1);

    // bus beats CPU on first tie, CPU wins the next tie
    do_reset();
    go(1); BLRQ_n = 1'b0; BWRITE_n = 1'b0;
    go(3); CRQ_n = 1'b0; CWRITE_n = 1'b1;
    go(4); check_vec("fair_bgnt4", BGNT_n, 1);
    go(5);
    check_vec("fair_bgnt5", BGNT_n, 0);
    check_vec("fair_cgnt5", CGNT_n, 1);
    check_vec("fair_mwr5", MWRITE_n, 0);
    go(7); BDRY_n = 1'b0;
    go(8); BDRY_n = 1'b1;
    check_vec("fair_brel8", BGNT_n, 1);
    go(11); check_vec("fair_cgnt11", CGNT_n, 1);
    go(12);
    check_vec("fair_cgnt12", CGNT_n, 0);
    check_vec("fair_bgnt12", BGNT_n, 1);
    check_vec("fair_mwr12", MWRITE_n, 1);
    // asynchronous reset in the middle of a grant
    #2 MR_n = 1'b0;
    #1;
    check_vec("async_cgnt", CGNT_n, 1);
    check_vec("async_gnt", GNT_n, 1);
    check_vec("async_mwr", MWRITE_n, 1);

    // locked bus cycles, broken by a pending refresh
    do_reset();
    go(1); BLRQ_n = 1'b0; BLOCKL_n = 1'b0;
    go(3); CRQ_n = 1'b0;
    go(5); check_vec("lock_bgnt5", BGNT_n, 0);
    for (int p = 7; p <= 13; p += 3) begin
      go(p); BDRY_n = 1'b0;
      go(p + 1); BDRY_n = 1'b1;
      check_vec("lock_bgnt", BGNT_n, 0);
      check_vec("lock_cgnt", CGNT_n, 1);
    end
    go(18); BDRY_n = 1'b0;
    check_vec("lock_bgnt18", BGNT_n, 0);
    go(19); BDRY_n = 1'b1;
    check_vec("lock_brk19", BGNT_n, 1);
    go(21); check_vec("lock_ref21", REF_n, 1);
    go(22);
    check_vec("lock_ref22", REF_n, 0);
    check_vec("lock_cgnt22", CGNT_n, 1);

    // refresh cadence, request held off by refresh and recovery
    do_reset();
    go(16); check_vec("ref_ref16", REF_n, 1);
    go(17);
    check_vec("ref_ref17", REF_n, 0);
    check_vec("ref_gnt17", GNT_n, 1);
    go(18); CRQ_n = 1'b0;
    go(24);
    check_vec("ref_ref24", REF_n, 0);
    check_vec("ref_cgnt24", CGNT_n, 1);
    go(25); check_vec("ref_ref25", REF_n, 1);
    go(27); check_vec("ref_cgnt27", CGNT_n, 1);
    go(28); check_vec("ref_cgnt28", CGNT_n, 1);
    go(29); check_vec("ref_cgnt29", CGNT_n, 0);
    CDONE_n = 1'b0; CRQ_n = 1'b1;
    go(30); CDONE_n = 1'b1;
    check_vec("ref_cgnt30", CGNT_n, 1);
    go(32); check_vec("ref_ref32", REF_n, 1);
    go(33); check_vec("ref_ref33", REF_n, 0);

    // memory off blocks grants but not refresh
    do_reset();
    MOR_n = 1'b0; CRQ_n = 1'b0; BLRQ_n = 1'b0;
    for (int c = 2; c <= 16; c += 2) begin
      go(c);
      check_vec("mor_gnt", GNT_n, 1);
    end
    go(17); check_vec("mor_ref17", REF_n, 0);

    // memory off during an active CPU grant
    do_reset();
    go(1); CRQ_n = 1'b0;
    go(3); check_vec("morc_cgnt3", CGNT_n, 0);
    go(4); MOR_n = 1'b0;
    go(6); check_vec("morc_cgnt6", CGNT_n, 0);
    CDONE_n = 1'b0;
    go(7); CDONE_n = 1'b1;
    check_vec("morc_cgnt7", CGNT_n, 1);
    go(10); check_vec("morc_gnt10", GNT_n, 1);
    go(11); check_vec("morc_gnt11", GNT_n, 1);

    // bus grant with no done
    do_reset();
    go(1); BLRQ_n = 1'b0;
    go(5); check_vec("wd_bgnt5", BGNT_n, 0);
    go(35);
    check_vec("wd_bgnt35", BGNT_n, 0);
    check_vec("wd_tout35", TOUT, 0);
    BLRQ_n = 1'b1;
    go(36);
`ifdef LBARB_TIMEOUT_EN
    check_vec("wd_bgnt36", BGNT_n, 1);
    check_vec("wd_tout36", TOUT, 1);
    go(40); check_vec("wd_tout40", TOUT, 1);
    MR_n = 1'b0;
    #1;
    check_vec("wd_tout_rst", TOUT, 0);
    MR_n = 1'b1;
`else
    check_vec("wd_bgnt36", BGNT_n, 0);
    check_vec("wd_tout36", TOUT, 0);
    go(40); check_vec("wd_bgnt40", BGNT_n, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
